// File: rtl/teclado_emulador_if.sv
// Keypad emulator bus: press-command handshake plus the row/column scan lines.
// The scanner/test harness side uses the master modport; the emulator uses slave.
interface teclado_emulador_if #(
    parameter int HOLD_W = 24
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_key;
    logic [HOLD_W-1:0] cmd_hold;
    logic [3:0]        columnas;
    logic [3:0]        filas;
    logic              contact;
    logic              busy;
    logic              done;

    modport master (
        output cmd_valid, cmd_key, cmd_hold, columnas,
        input  cmd_ready, filas, contact, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_key, cmd_hold, columnas,
        output cmd_ready, filas, contact, busy, done
    );
endinterface

// File: rtl/teclado_emulador.sv
// 4x4 matrix keypad emulator, passive end of a column-scan interface.
// Accepts one key press at a time and plays it out as make bounce, hold,
// break bounce and a released gap, answering the active-low column strobes
// with the active-low row pattern of the latched key while contact is closed.
module teclado_emulador #(
    parameter int BOUNCE_TOGGLES = 4,
    parameter int BOUNCE_PERIOD  = 64,
    parameter int GAP_CYCLES     = 1000,
    parameter int HOLD_W         = 24
) (
    input  logic               clk,
    input  logic               rst,
    teclado_emulador_if.slave  bus
);

    // One shared down-counter serves the bounce periods, the hold and the gap,
    // so it is as wide as the widest of the three.
    localparam int PER_W   = (BOUNCE_PERIOD > 1) ? $clog2(BOUNCE_PERIOD) : 1;
    localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int MAX_PG  = (PER_W > GAP_W) ? PER_W : GAP_W;
    localparam int CNT_W   = (HOLD_W > MAX_PG) ? HOLD_W : MAX_PG;
    localparam int PH_W    = (2 * BOUNCE_TOGGLES > 2) ? $clog2(2 * BOUNCE_TOGGLES) : 1;
    localparam int PH_LAST = (BOUNCE_TOGGLES > 0) ? 2 * BOUNCE_TOGGLES - 1 : 0;

    localparam logic [CNT_W-1:0] PER_LOAD = CNT_W'(BOUNCE_PERIOD - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BOUNCE_IN,
        S_HOLD,
        S_BOUNCE_OUT,
        S_GAP
    } state_t;

    state_t            r_state;
    state_t            w_stateNext;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cntNext;
    logic [PH_W-1:0]   r_phase;
    logic [PH_W-1:0]   w_phaseNext;
    logic              r_contact;
    logic              w_contactNext;
    logic              r_done;
    logic              w_doneNext;
    logic [3:0]        r_key;
    logic [HOLD_W-1:0] r_holdLoad;
    logic [3:0]        r_filas;

    logic              w_accept;
    logic              w_cntZero;
    logic              w_lastPhase;
    logic [HOLD_W-1:0] w_busHoldLoad;
    logic [1:0]        w_col;
    logic [3:0]        w_rowPat;

    assign w_accept      = bus.cmd_valid && (r_state == S_IDLE) && !rst;
    assign w_cntZero     = (r_cnt == '0);
    assign w_lastPhase   = (r_phase == PH_W'(PH_LAST));
    // A hold of zero is stretched to one clock; the counter holds length-1.
    assign w_busHoldLoad = (bus.cmd_hold == '0) ? '0 : bus.cmd_hold - HOLD_W'(1);

    assign bus.cmd_ready = (r_state == S_IDLE) && !rst;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.contact   = r_contact;
    assign bus.done      = r_done;
    assign bus.filas     = r_filas;

    // State, counters, contact and done pulse advance together on each edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_phase   <= '0;
            r_contact <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_cnt     <= w_cntNext;
            r_phase   <= w_phaseNext;
            r_contact <= w_contactNext;
            r_done    <= w_doneNext;
        end
    end

    // Latch the key and the reduced hold length when a command is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key      <= 4'h0;
            r_holdLoad <= '0;
        end else if (w_accept) begin
            r_key      <= bus.cmd_key;
            r_holdLoad <= w_busHoldLoad;
        end
    end

    // Next-state logic: every state entry reloads the counter and sets the
    // contact level for the first clock spent in that state.
    always_comb begin
        w_stateNext   = r_state;
        w_cntNext     = r_cnt;
        w_phaseNext   = r_phase;
        w_contactNext = r_contact;
        w_doneNext    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_contactNext = 1'b0;
                if (w_accept) begin
                    w_contactNext = 1'b1;
                    if (BOUNCE_TOGGLES == 0) begin
                        w_stateNext = S_HOLD;
                        w_cntNext   = CNT_W'(w_busHoldLoad);
                    end else begin
                        w_stateNext = S_BOUNCE_IN;
                        w_cntNext   = PER_LOAD;
                        w_phaseNext = '0;
                    end
                end
            end
            S_BOUNCE_IN: begin
                if (!w_cntZero) begin
                    w_cntNext = r_cnt - CNT_W'(1);
                end else if (w_lastPhase) begin
                    w_stateNext   = S_HOLD;
                    w_cntNext     = CNT_W'(r_holdLoad);
                    w_contactNext = 1'b1;
                end else begin
                    w_phaseNext   = r_phase + PH_W'(1);
                    w_cntNext     = PER_LOAD;
                    w_contactNext = ~r_contact;
                end
            end
            S_HOLD: begin
                if (!w_cntZero) begin
                    w_cntNext = r_cnt - CNT_W'(1);
                end else begin
                    w_contactNext = 1'b0;
                    if (BOUNCE_TOGGLES == 0) begin
                        w_stateNext = S_GAP;
                        w_cntNext   = GAP_LOAD;
                    end else begin
                        w_stateNext = S_BOUNCE_OUT;
                        w_cntNext   = PER_LOAD;
                        w_phaseNext = '0;
                    end
                end
            end
            S_BOUNCE_OUT: begin
                if (!w_cntZero) begin
                    w_cntNext = r_cnt - CNT_W'(1);
                end else if (w_lastPhase) begin
                    w_stateNext   = S_GAP;
                    w_cntNext     = GAP_LOAD;
                    w_contactNext = 1'b0;
                end else begin
                    w_phaseNext   = r_phase + PH_W'(1);
                    w_cntNext     = PER_LOAD;
                    w_contactNext = ~r_contact;
                end
            end
            S_GAP: begin
                w_contactNext = 1'b0;
                if (!w_cntZero) begin
                    w_cntNext = r_cnt - CNT_W'(1);
                end else begin
                    w_stateNext = S_IDLE;
                    w_doneNext  = 1'b1;
                end
            end
            default: begin
                w_stateNext   = S_IDLE;
                w_contactNext = 1'b0;
            end
        endcase
    end

    // Key map: column index that strobes the key and the row it pulls low.
    always_comb begin
        w_col = 2'd0;
        case (r_key)
            4'h1: w_col = 2'd0;
            4'h4: w_col = 2'd0;
            4'h7: w_col = 2'd0;
            4'hE: w_col = 2'd0;
            4'h2: w_col = 2'd1;
            4'h5: w_col = 2'd1;
            4'h8: w_col = 2'd1;
            4'h0: w_col = 2'd1;
            4'h3: w_col = 2'd2;
            4'h6: w_col = 2'd2;
            4'h9: w_col = 2'd2;
            4'hF: w_col = 2'd2;
            default: w_col = 2'd3;
        endcase
        w_rowPat = 4'b0111;
        case (r_key)
            4'h1, 4'h2, 4'h3, 4'hA: w_rowPat = 4'b0111;
            4'h4, 4'h5, 4'h6, 4'hB: w_rowPat = 4'b1011;
            4'h7, 4'h8, 4'h9, 4'hC: w_rowPat = 4'b1101;
            default:                w_rowPat = 4'b1110;
        endcase
    end

    // Rows answer the column strobe one clock later; column c sits on bit 3-c,
    // which is the bitwise complement of the 2-bit column index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_filas <= 4'hF;
        end else if (r_contact && !bus.columnas[~w_col]) begin
            r_filas <= w_rowPat;
        end else begin
            r_filas <= 4'hF;
        end
    end

endmodule
